nes_poll_scheduler: RTL and testbench

Sequences the NES serial controller protocol for two ports that share one latch and one sclk line, each with its own sdata line. Polls are triggered by a free-running rate timer or by a host request. Each poll captures the 8 button bits from both pads and publishes them with a one-cycle valid strobe and per-button press-edge flags. The block sits between the pad pins and the top-level LED/game logic, and replaces ad-hoc latch/sclk generation.

---
 rtl/nes_poll_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_nes_poll_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_poll_scheduler.sv
// Two-port NES pad poller: drives the shared latch/sclk pair, captures both
// serial streams and publishes button snapshots with press-edge flags.
module nes_poll_scheduler #(
  parameter int LATCH_CYCLES = 144,
  parameter int HALF_CYCLES  = 72,
  parameter int POLL_CYCLES  = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       poll_req,
  input  logic [1:0] sdata,
  output logic       latch,
  output logic       sclk,
  output logic [1:0] state,
  output logic       busy,
  output logic [7:0] buttons1,
  output logic [7:0] buttons2,
  output logic       valid,
  output logic [7:0] pressed1,
  output logic [7:0] pressed2
);

  localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam int HW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  // One phase counter serves both LATCH and CAPTURE, so it takes the wider width
  localparam int CW = (LW > HW) ? LW : HW;

  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [PW-1:0] TIMER_ONE  = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_LATCH   = 2'b01,
    ST_CAPTURE = 2'b11,
    ST_DONE    = 2'b10
  } state_e;

  state_e          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [2:0]      bit_r, bit_s;
  logic            low_r, low_s;
  logic            pending_r, pending_s;
  logic [PW-1:0]   timer_r, timer_s;
  logic            tick_s;
  logic            trigger_s;
  logic            sample_s;
  logic [2:0]      sample_idx_s;
  logic [7:0]      cap1_r, cap2_r;
  logic            latch_r, sclk_r, busy_r, valid_r;
  logic [7:0]      buttons1_r, buttons2_r, pressed1_r, pressed2_r;

  // Rate timer next value and wrap tick
  always_comb begin
    timer_s = '0;
    tick_s  = 1'b0;
    if (enable) begin
      if (timer_r == POLL_LAST) begin
        timer_s = '0;
        tick_s  = 1'b1;
      end else begin
        timer_s = timer_r + TIMER_ONE;
        tick_s  = 1'b0;
      end
    end else begin
      timer_s = '0;
      tick_s  = 1'b0;
    end
  end

  assign trigger_s = tick_s | poll_req | pending_r;

  // Poll sequencer next-state, counters, sample strobes and pending merge
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    bit_s        = bit_r;
    low_s        = low_r;
    pending_s    = pending_r;
    sample_s     = 1'b0;
    sample_idx_s = 3'd0;
    case (state_r)
      ST_IDLE: begin
        pending_s = 1'b0;
        if (trigger_s) begin
          state_s = ST_LATCH;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LATCH: begin
        pending_s = pending_r | tick_s | poll_req;
        if (cnt_r == LATCH_LAST) begin
          state_s      = ST_CAPTURE;
          cnt_s        = '0;
          bit_s        = 3'd1;
          low_s        = 1'b1;
          sample_s     = 1'b1;
          sample_idx_s = 3'd0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_CAPTURE: begin
        pending_s = pending_r | tick_s | poll_req;
        if (cnt_r == HALF_LAST) begin
          cnt_s = '0;
          // Bit k is taken on the last clk of the k-th low phase
          if (low_r) begin
            low_s        = 1'b0;
            sample_s     = 1'b1;
            sample_idx_s = bit_r;
          end else if (bit_r == 3'd7) begin
            state_s = ST_DONE;
          end else begin
            bit_s = bit_r + 3'd1;
            low_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        pending_s = pending_r | tick_s | poll_req;
        state_s   = ST_IDLE;
      end
      default: begin
        state_s   = ST_IDLE;
        cnt_s     = '0;
        bit_s     = 3'd0;
        low_s     = 1'b0;
        pending_s = 1'b0;
      end
    endcase
  end

  // Sequencer state, phase counters, pending flag and rate timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      bit_r     <= 3'd0;
      low_r     <= 1'b0;
      pending_r <= 1'b0;
      timer_r   <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_r     <= bit_s;
      low_r     <= low_s;
      pending_r <= pending_s;
      timer_r   <= timer_s;
    end
  end

  // Capture bytes; the wire is active-low so each sample is inverted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap1_r <= 8'h00;
      cap2_r <= 8'h00;
    end else if (sample_s) begin
      cap1_r[sample_idx_s] <= ~sdata[0];
      cap2_r[sample_idx_s] <= ~sdata[1];
    end
  end

  // Pin drives and published snapshot, all registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latch_r    <= 1'b0;
      sclk_r     <= 1'b1;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      buttons1_r <= 8'h00;
      buttons2_r <= 8'h00;
      pressed1_r <= 8'h00;
      pressed2_r <= 8'h00;
    end else begin
      latch_r <= (state_s == ST_LATCH);
      sclk_r  <= ~((state_s == ST_CAPTURE) && low_s);
      busy_r  <= (state_s != ST_IDLE);
      valid_r <= (state_r == ST_DONE);
      if (state_r == ST_DONE) begin
        buttons1_r <= cap1_r;
        buttons2_r <= cap2_r;
        pressed1_r <= cap1_r & ~buttons1_r;
        pressed2_r <= cap2_r & ~buttons2_r;
      end
    end
  end

  assign latch    = latch_r;
  assign sclk     = sclk_r;
  assign state    = state_r;
  assign busy     = busy_r;
  assign valid    = valid_r;
  assign buttons1 = buttons1_r;
  assign buttons2 = buttons2_r;
  assign pressed1 = pressed1_r;
  assign pressed2 = pressed2_r;

endmodule

// File: tb/tb_nes_poll_scheduler.sv
// Scoreboard bench for nes_poll_scheduler: behavioural pads on the pins,
// expected snapshots queued at stimulus time and checked on each valid.
module tb_nes_poll_scheduler;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       poll_req;
  logic [1:0] sdata;
  logic       latch, sclk, busy, valid;
  logic [1:0] state;
  logic [7:0] buttons1, buttons2, pressed1, pressed2;

  typedef struct {
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] p1;
    logic [7:0] p2;
    int         vcyc;
  } exp_t;

  exp_t       sb[$];
  int         rises[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pad_idx = 0;
  logic [7:0] pad1_btn = 8'h00;
  logic [7:0] pad2_btn = 8'h00;
  logic [7:0] prev1 = 8'h00;
  logic [7:0] prev2 = 8'h00;
  logic       force_high = 1'b0;

  nes_poll_scheduler #(
    .LATCH_CYCLES(8),
    .HALF_CYCLES (4),
    .POLL_CYCLES (200)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .poll_req(poll_req),
    .sdata   (sdata),
    .latch   (latch),
    .sclk    (sclk),
    .state   (state),
    .busy    (busy),
    .buttons1(buttons1),
    .buttons2(buttons2),
    .valid   (valid),
    .pressed1(pressed1),
    .pressed2(pressed2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  // Pads present bit 0 while latched and advance one bit per falling sclk
  assign sdata = force_high ? 2'b11 : {~pad2_btn[pad_idx[2:0]], ~pad1_btn[pad_idx[2:0]]};

  initial begin : pad_model
    logic prev_sclk;
    prev_sclk = 1'b1;
    forever begin
      @(negedge clk);
      if (latch) pad_idx = 0;
      else if (prev_sclk && !sclk && pad_idx < 7) pad_idx = pad_idx + 1;
      prev_sclk = sclk;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [7:0] e1, input logic [7:0] e2, input int vcyc);
    exp_t e;
    e.b1   = e1;
    e.b2   = e2;
    e.p1   = e1 & ~prev1;
    e.p2   = e2 & ~prev2;
    e.vcyc = vcyc;
    prev1  = e1;
    prev2  = e2;
    sb.push_back(e);
  endtask

  task automatic issue_poll(input logic [7:0] p1v, input logic [7:0] p2v,
                            input logic [7:0] e1, input logic [7:0] e2);
    pad1_btn = p1v;
    pad2_btn = p2v;
    @(negedge clk);
    push_exp(e1, e2, cyc + 66);
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 600) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("drain_timeout", sb.size(), 0);
    repeat (4) @(negedge clk);
    chk("idle_after_poll", busy, 0);
  endtask

  initial begin : monitor
    int   latch_run, low_run, high_run, pulses;
    logic prev_latch;
    exp_t e;
    latch_run = 0; low_run = 0; high_run = 0; pulses = 0; prev_latch = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        latch_run = 0; low_run = 0; high_run = 0; pulses = 0; prev_latch = 1'b0;
      end else begin
        if (latch && !prev_latch) rises.push_back(cyc);
        prev_latch = latch;
        if (latch) latch_run = latch_run + 1;
        else if (latch_run != 0) begin
          chk("latch_width", latch_run, 8);
          latch_run = 0;
        end
        if (!sclk) begin
          if (low_run == 0 && pulses != 0) chk("sclk_high_width", high_run, 4);
          low_run  = low_run + 1;
          high_run = 0;
        end else begin
          if (low_run != 0) begin
            chk("sclk_low_width", low_run, 4);
            pulses  = pulses + 1;
            low_run = 0;
          end
          high_run = high_run + 1;
        end
        if (valid) begin
          chk("sclk_pulses", pulses, 7);
          pulses = 0;
          chk("state_at_valid", state, 0);
          if (sb.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_valid: valid=1 at cycle %0d, expected no valid", cyc);
          end else begin
            e = sb.pop_front();
            chk("valid_cycle", cyc, e.vcyc);
            chk("buttons1", buttons1, e.b1);
            chk("buttons2", buttons2, e.b2);
            chk("pressed1", pressed1, e.p1);
            chk("pressed2", pressed2, e.p2);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int         n0;
    logic [7:0] w1, w2;
    reset = 1'b0; enable = 1'b0; poll_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_latch", latch, 0);
    chk("reset_sclk", sclk, 1);
    chk("reset_state", state, 0);
    chk("reset_busy", busy, 0);
    chk("reset_valid", valid, 0);
    chk("reset_outputs", {buttons1, buttons2, pressed1, pressed2}, 0);
    reset = 1'b1;

    // Single request, pad 1 holds A
    issue_poll(8'h01, 8'h00, 8'h01, 8'h00);
    drain();

    // A still held, then release A and press START+RIGHT on pad 2
    issue_poll(8'h01, 8'h00, 8'h01, 8'h00);
    drain();
    issue_poll(8'h00, 8'h88, 8'h00, 8'h88);
    drain();

    // Timer-driven polls every 200 cycles, then disabled
    pad1_btn = 8'h10; pad2_btn = 8'h20;
    rises.delete();
    @(negedge clk);
    n0 = cyc;
    enable = 1'b1;
    push_exp(8'h10, 8'h20, n0 + 265);
    push_exp(8'h10, 8'h20, n0 + 465);
    push_exp(8'h10, 8'h20, n0 + 665);
    repeat (700) @(negedge clk);
    enable = 1'b0;
    repeat (400) @(negedge clk);
    chk("timer_poll_count", rises.size(), 3);
    if (rises.size() == 3) begin
      chk("timer_first_rise", rises[0], n0 + 200);
      chk("timer_interval_1", rises[1] - rises[0], 200);
      chk("timer_interval_2", rises[2] - rises[1], 200);
    end
    drain();

    // Requests during CAPTURE merge into one pending poll
    pad1_btn = 8'h5A; pad2_btn = 8'hC3;
    rises.delete();
    @(negedge clk);
    n0 = cyc;
    push_exp(8'h5A, 8'hC3, n0 + 66);
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    repeat (18) @(negedge clk);
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    repeat (10) @(negedge clk);
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    push_exp(8'h5A, 8'hC3, n0 + 132);
    drain();
    repeat (200) @(negedge clk);
    chk("pending_poll_count", rises.size(), 2);
    if (rises.size() == 2) chk("pending_restart_gap", rises[1] - rises[0], 66);

    // Tick and request in the same cycle give one poll
    @(negedge clk);
    n0 = cyc;
    enable = 1'b1;
    repeat (199) @(negedge clk);
    push_exp(8'h5A, 8'hC3, n0 + 265);
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    repeat (10) @(negedge clk);
    enable = 1'b0;
    drain();
    repeat (300) @(negedge clk);

    // Reset in the middle of CAPTURE aborts without an update
    @(negedge clk);
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_latch", latch, 0);
    chk("abort_sclk", sclk, 1);
    chk("abort_state", state, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_outputs", {buttons1, buttons2, pressed1, pressed2}, 0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    prev1 = 8'h00; prev2 = 8'h00;
    repeat (300) @(negedge clk);
    chk("post_reset_idle", busy, 0);

    // Disconnected pads read as zero regardless of pad contents
    force_high = 1'b1;
    issue_poll(8'hFF, 8'hFF, 8'h00, 8'h00);
    drain();
    force_high = 1'b0;

    // Walking single pressed button across every bit position
    for (int i = 0; i < 8; i++) begin
      w1 = 8'h01 << i;
      w2 = 8'h80 >> i;
      issue_poll(w1, w2, w1, w2);
      drain();
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
